// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch controller.
// Owns the PC, drives a req/ack instruction memory, holds the fetched
// instruction across decode stalls and applies branch redirects,
// including redirects that arrive while a fetch is still in flight.
// Misaligned redirect targets and memory timeouts latch a sticky error.
module fetch_sequencer #(
    parameter int unsigned            WORD      = 64,
    parameter int unsigned            INSTR_LEN = 32,
    parameter logic [WORD-1:0]        RESET_PC  = '0,
    parameter int unsigned            MAX_WAIT  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 pc_src,
    input  logic [WORD-1:0]      branch_target,
    output logic                 mem_req,
    output logic [WORD-1:0]      mem_addr,
    input  logic                 mem_ack,
    input  logic [INSTR_LEN-1:0] mem_rdata,
    output logic                 instr_valid,
    output logic [INSTR_LEN-1:0] instruction,
    output logic [WORD-1:0]      cur_pc,
    output logic                 fetch_err
);

    localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        VALID  = 3'd2,
        SQUASH = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t                 r_state,       w_state;
    logic [WORD-1:0]        r_pc,          w_pc;
    logic                   r_mem_req,     w_mem_req;
    logic [WORD-1:0]        r_mem_addr,    w_mem_addr;
    logic                   r_instr_valid, w_instr_valid;
    logic [INSTR_LEN-1:0]   r_instruction, w_instruction;
    logic [WORD-1:0]        r_cur_pc,      w_cur_pc;
    logic                   r_fetch_err,   w_fetch_err;
    logic [CW-1:0]          r_cnt,         w_cnt;

    logic                   w_misaligned;
    logic                   w_timeout;

    assign w_misaligned = pc_src && (branch_target[1:0] != 2'b00);
    // The current ack-less cycle is the MAX_WAIT-th one in a row.
    assign w_timeout    = (r_cnt == CW'(MAX_WAIT - 1));

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_valid = r_instr_valid;
    assign instruction = r_instruction;
    assign cur_pc      = r_cur_pc;
    assign fetch_err   = r_fetch_err;

    // State and registered outputs; reset abandons any outstanding fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_instruction <= '0;
            r_cur_pc      <= RESET_PC;
            r_fetch_err   <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state;
            r_pc          <= w_pc;
            r_mem_req     <= w_mem_req;
            r_mem_addr    <= w_mem_addr;
            r_instr_valid <= w_instr_valid;
            r_instruction <= w_instruction;
            r_cur_pc      <= w_cur_pc;
            r_fetch_err   <= w_fetch_err;
            r_cnt         <= w_cnt;
        end
    end

    // Next-state and next-output logic; a misaligned redirect overrides all.
    always_comb begin
        w_state       = r_state;
        w_pc          = r_pc;
        w_mem_req     = r_mem_req;
        w_mem_addr    = r_mem_addr;
        w_instr_valid = r_instr_valid;
        w_instruction = r_instruction;
        w_cur_pc      = r_cur_pc;
        w_fetch_err   = r_fetch_err;
        w_cnt         = r_cnt;

        if (r_state != ERR && w_misaligned) begin
            w_state       = ERR;
            w_mem_req     = 1'b0;
            w_instr_valid = 1'b0;
            w_fetch_err   = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state   = REQ;
                    w_mem_req = 1'b1;
                    w_cnt     = '0;
                    if (pc_src) begin
                        w_pc       = branch_target;
                        w_mem_addr = branch_target;
                    end else begin
                        w_mem_addr = r_pc;
                    end
                end

                REQ: begin
                    if (mem_ack) begin
                        w_mem_req = 1'b0;
                        if (pc_src) begin
                            w_pc    = branch_target;
                            w_state = IDLE;
                        end else begin
                            w_instruction = mem_rdata;
                            w_cur_pc      = r_mem_addr;
                            w_pc          = r_mem_addr + WORD'(4);
                            w_instr_valid = 1'b1;
                            w_state       = VALID;
                        end
                    end else if (w_timeout) begin
                        w_state     = ERR;
                        w_mem_req   = 1'b0;
                        w_fetch_err = 1'b1;
                    end else begin
                        w_cnt = r_cnt + CW'(1);
                        // Memory cannot abort: keep the request up, drain it in SQUASH.
                        if (pc_src) begin
                            w_pc    = branch_target;
                            w_state = SQUASH;
                        end
                    end
                end

                VALID: begin
                    if (pc_src) begin
                        w_instr_valid = 1'b0;
                        w_pc          = branch_target;
                        w_state       = IDLE;
                    end else if (!stall) begin
                        w_instr_valid = 1'b0;
                        w_mem_req     = 1'b1;
                        w_mem_addr    = r_pc;
                        w_cnt         = '0;
                        w_state       = REQ;
                    end
                end

                SQUASH: begin
                    if (pc_src) begin
                        w_pc = branch_target;
                    end
                    if (mem_ack) begin
                        w_mem_req = 1'b0;
                        w_state   = IDLE;
                    end else if (w_timeout) begin
                        w_state     = ERR;
                        w_mem_req   = 1'b0;
                        w_fetch_err = 1'b1;
                    end else begin
                        w_cnt = r_cnt + CW'(1);
                    end
                end

                ERR: begin
                    w_mem_req     = 1'b0;
                    w_instr_valid = 1'b0;
                    w_fetch_err   = 1'b1;
                end

                default: begin
                    w_state = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one instance at RESET_PC=0 and one
// at RESET_PC=2^64-4 for wrap-around and misaligned-redirect behaviour.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset_a, reset_b;

    logic        a_stall, a_pc_src, a_mem_ack;
    logic [63:0] a_branch_target;
    logic [31:0] a_mem_rdata;
    logic        a_mem_req, a_instr_valid, a_fetch_err;
    logic [63:0] a_mem_addr, a_cur_pc;
    logic [31:0] a_instruction;

    logic        b_stall, b_pc_src, b_mem_ack;
    logic [63:0] b_branch_target;
    logic [31:0] b_mem_rdata;
    logic        b_mem_req, b_instr_valid, b_fetch_err;
    logic [63:0] b_mem_addr, b_cur_pc;
    logic [31:0] b_instruction;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    fetch_sequencer #(
        .WORD      (64),
        .INSTR_LEN (32),
        .RESET_PC  (64'h0),
        .MAX_WAIT  (15)
    ) u_dut_a (
        .clk           (clk),
        .reset         (reset_a),
        .stall         (a_stall),
        .pc_src        (a_pc_src),
        .branch_target (a_branch_target),
        .mem_req       (a_mem_req),
        .mem_addr      (a_mem_addr),
        .mem_ack       (a_mem_ack),
        .mem_rdata     (a_mem_rdata),
        .instr_valid   (a_instr_valid),
        .instruction   (a_instruction),
        .cur_pc        (a_cur_pc),
        .fetch_err     (a_fetch_err)
    );

    fetch_sequencer #(
        .WORD      (64),
        .INSTR_LEN (32),
        .RESET_PC  (64'hFFFF_FFFF_FFFF_FFFC),
        .MAX_WAIT  (15)
    ) u_dut_b (
        .clk           (clk),
        .reset         (reset_b),
        .stall         (b_stall),
        .pc_src        (b_pc_src),
        .branch_target (b_branch_target),
        .mem_req       (b_mem_req),
        .mem_addr      (b_mem_addr),
        .mem_ack       (b_mem_ack),
        .mem_rdata     (b_mem_rdata),
        .instr_valid   (b_instr_valid),
        .instruction   (b_instruction),
        .cur_pc        (b_cur_pc),
        .fetch_err     (b_fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge, then settle so inputs/outputs are away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // DUT A is in REQ at exp_addr: hold ack off for 'delay' cycles, then ack.
    task automatic fetch_a(input logic [63:0] exp_addr, input int unsigned delay,
                           input logic [31:0] data);
        check("req_up",   64'(a_mem_req), 64'd1);
        check("req_addr", a_mem_addr, exp_addr);
        for (int unsigned i = 0; i < delay; i++) begin
            tick();
            check("req_hold",      64'(a_mem_req), 64'd1);
            check("req_addr_hold", a_mem_addr, exp_addr);
        end
        a_mem_ack   = 1'b1;
        a_mem_rdata = data;
        tick();
        a_mem_ack   = 1'b0;
        a_mem_rdata = 32'hDEAD_BEEF;
        check("valid",     64'(a_instr_valid), 64'd1);
        check("instr",     64'(a_instruction), 64'(data));
        check("cur_pc",    a_cur_pc, exp_addr);
        check("req_drop",  64'(a_mem_req), 64'd0);
    endtask

    task automatic check_a_reset();
        check("rst_req",   64'(a_mem_req), 64'd0);
        check("rst_addr",  a_mem_addr, 64'd0);
        check("rst_valid", 64'(a_instr_valid), 64'd0);
        check("rst_instr", 64'(a_instruction), 64'd0);
        check("rst_curpc", a_cur_pc, 64'd0);
        check("rst_err",   64'(a_fetch_err), 64'd0);
    endtask

    initial begin
        reset_a = 1'b0; reset_b = 1'b0;
        a_stall = 1'b0; a_pc_src = 1'b0; a_mem_ack = 1'b0;
        a_branch_target = '0; a_mem_rdata = '0;
        b_stall = 1'b0; b_pc_src = 1'b0; b_mem_ack = 1'b0;
        b_branch_target = '0; b_mem_rdata = '0;

        tick(); tick();
        check_a_reset();

        // Sequential fetches with a 2-cycle ack latency.
        reset_a = 1'b1;
        tick();
        fetch_a(64'd0, 1, 32'h1111_0000);
        tick();
        check("consume_valid", 64'(a_instr_valid), 64'd0);
        fetch_a(64'd4, 1, 32'h2222_0004);

        // Stall in VALID at cur_pc=4.
        a_stall = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 64'(a_instr_valid), 64'd1);
            check("stall_instr", 64'(a_instruction), 64'h2222_0004);
            check("stall_curpc", a_cur_pc, 64'd4);
            check("stall_req",   64'(a_mem_req), 64'd0);
        end
        a_stall = 1'b0;
        tick();
        fetch_a(64'd8, 1, 32'h3333_0008);

        // Redirect from VALID to 36.
        a_pc_src = 1'b1; a_branch_target = 64'd36;
        tick();
        a_pc_src = 1'b0; a_branch_target = '0;
        check("redir_valid", 64'(a_instr_valid), 64'd0);
        check("redir_req",   64'(a_mem_req), 64'd0);
        tick();
        fetch_a(64'd36, 0, 32'h4444_0024);
        tick();
        check("after_redir_addr", a_mem_addr, 64'd40);

        // Redirect to 24 while REQ at 40 is outstanding.
        a_pc_src = 1'b1; a_branch_target = 64'd24;
        tick();
        a_pc_src = 1'b0; a_branch_target = '0;
        check("squash_req",  64'(a_mem_req), 64'd1);
        check("squash_addr", a_mem_addr, 64'd40);
        tick();
        check("squash_addr2", a_mem_addr, 64'd40);
        a_mem_ack = 1'b1; a_mem_rdata = 32'hBAD0_0028;
        tick();
        check("squash_drop_valid", 64'(a_instr_valid), 64'd0);
        check("squash_drop_req",   64'(a_mem_req), 64'd0);
        // Ack left high while mem_req=0 must be ignored.
        tick();
        a_mem_ack = 1'b0;
        check("post_squash_req",   64'(a_mem_req), 64'd1);
        check("post_squash_addr",  a_mem_addr, 64'd24);
        check("post_squash_valid", 64'(a_instr_valid), 64'd0);

        // Timeout: 15 ack-less cycles from entering REQ.
        for (int unsigned i = 0; i < 14; i++) tick();
        check("pre_to_err", 64'(a_fetch_err), 64'd0);
        check("pre_to_req", 64'(a_mem_req), 64'd1);
        tick();
        check("to_err", 64'(a_fetch_err), 64'd1);
        check("to_req", 64'(a_mem_req), 64'd0);
        a_pc_src = 1'b1; a_branch_target = 64'd0; a_mem_ack = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check("sticky_err",   64'(a_fetch_err), 64'd1);
            check("sticky_req",   64'(a_mem_req), 64'd0);
            check("sticky_valid", 64'(a_instr_valid), 64'd0);
        end
        a_pc_src = 1'b0; a_mem_ack = 1'b0;

        // Asynchronous reset in the middle of a REQ.
        reset_a = 1'b0;
        tick();
        reset_a = 1'b1;
        tick();
        tick();
        check("mid_req", 64'(a_mem_req), 64'd1);
        #2 reset_a = 1'b0;
        #1;
        check_a_reset();

        // Wrap-around and misaligned redirect on DUT B.
        reset_b = 1'b1;
        tick();
        check("b_req",  64'(b_mem_req), 64'd1);
        check("b_addr", b_mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        b_mem_ack = 1'b1; b_mem_rdata = 32'h5555_AAAA;
        tick();
        b_mem_ack = 1'b0;
        check("b_valid", 64'(b_instr_valid), 64'd1);
        check("b_instr", 64'(b_instruction), 64'h5555_AAAA);
        check("b_curpc", b_cur_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("b_wrap_addr", b_mem_addr, 64'd0);
        check("b_wrap_req",  64'(b_mem_req), 64'd1);
        b_pc_src = 1'b1; b_branch_target = 64'd38;
        tick();
        b_pc_src = 1'b0;
        check("b_mis_err", 64'(b_fetch_err), 64'd1);
        check("b_mis_req", 64'(b_mem_req), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
